// File: rtl/mnist_axil_pkg.sv
// Shared register map, AXI response codes and sequencer state encoding for
// the MNIST bias/control register block and its configuration masters.
package mnist_axil_pkg;

  localparam logic [4:0] BIAS_BASE   = 5'd0;
  localparam logic [4:0] CTRL_ADDR   = 5'd18;
  localparam logic [4:0] STATUS_ADDR = 5'd19;
  localparam int         NUM_BIAS    = 18;
  localparam int         POLL_LIMIT  = 1024;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WRITE,
    ST_WRESP,
    ST_POLL_AR,
    ST_POLL_R,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/bias_config_sequencer.sv
// AXI4-Lite master that streams NUM_BIAS bias words into the register bank,
// writes the control register to launch the datapath, then polls status
// until ready (done pulse) or until POLL_LIMIT reads have failed (error).
module bias_config_sequencer #(
  parameter int                ADDR_W      = 5,
  parameter int                NUM_BIAS    = mnist_axil_pkg::NUM_BIAS,
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(mnist_axil_pkg::CTRL_ADDR),
  parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(mnist_axil_pkg::STATUS_ADDR),
  parameter int                POLL_LIMIT  = mnist_axil_pkg::POLL_LIMIT
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [31:0]       s_bias_tdata,
  input  logic              s_bias_tvalid,
  output logic              s_bias_tready,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  output logic [2:0]        m_axil_awprot,
  output logic              m_axil_awvalid,
  input  logic              m_axil_awready,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  output logic              m_axil_wvalid,
  input  logic              m_axil_wready,
  input  logic [1:0]        m_axil_bresp,
  input  logic              m_axil_bvalid,
  output logic              m_axil_bready,
  output logic [ADDR_W-1:0] m_axil_araddr,
  output logic [2:0]        m_axil_arprot,
  output logic              m_axil_arvalid,
  input  logic              m_axil_arready,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp,
  input  logic              m_axil_rvalid,
  output logic              m_axil_rready
);
  import mnist_axil_pkg::*;

  localparam int                PCW       = $clog2(POLL_LIMIT) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_BIAS - 1);
  localparam logic [PCW-1:0]    POLL_LAST = PCW'(POLL_LIMIT - 1);

  seq_state_e        state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [PCW-1:0]    poll_cnt;
  logic              phase_ctrl;   // 0: streaming bias words, 1: control write
  logic              aw_done;      // AW handshake already taken this write
  logic              w_done;       // W handshake already taken this write
  logic              error_q;
  logic              aw_ok, w_ok;

  // Only bit 0 of the status word carries meaning.
  logic unused_rdata;
  assign unused_rdata = ^m_axil_rdata[31:1];

  // A channel counts as complete once its handshake happened now or earlier.
  assign aw_ok = aw_done | m_axil_awready;
  assign w_ok  = w_done  | m_axil_wready;

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (start) state_nxt = ST_FETCH;
      ST_FETCH:   if (s_bias_tvalid) state_nxt = ST_WRITE;
      ST_WRITE:   if (aw_ok && w_ok) state_nxt = ST_WRESP;
      ST_WRESP: begin
        if (m_axil_bvalid) begin
          if (m_axil_bresp != RESP_OKAY) state_nxt = ST_IDLE;
          else if (phase_ctrl)           state_nxt = ST_POLL_AR;
          else if (idx == LAST_IDX)      state_nxt = ST_WRITE;
          else                           state_nxt = ST_FETCH;
        end
      end
      ST_POLL_AR: if (m_axil_arready) state_nxt = ST_POLL_R;
      ST_POLL_R: begin
        if (m_axil_rvalid) begin
          if (m_axil_rresp != RESP_OKAY) state_nxt = ST_IDLE;
          else if (m_axil_rdata[0])      state_nxt = ST_FINISH;
          else if (poll_cnt == POLL_LAST) state_nxt = ST_IDLE;
          else                           state_nxt = ST_POLL_AR;
        end
      end
      ST_FINISH:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: word index, poll counter, held AW/W payload, sticky error.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      idx        <= '0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      poll_cnt   <= '0;
      phase_ctrl <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (state != ST_WRITE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            error_q    <= 1'b0;
            idx        <= '0;
            poll_cnt   <= '0;
            phase_ctrl <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (s_bias_tvalid) begin
            wdata_q  <= s_bias_tdata;
            awaddr_q <= idx;
          end
        end
        ST_WRITE: begin
          if (m_axil_awready) aw_done <= 1'b1;
          if (m_axil_wready)  w_done  <= 1'b1;
        end
        ST_WRESP: begin
          if (m_axil_bvalid) begin
            if (m_axil_bresp != RESP_OKAY) begin
              error_q <= 1'b1;
            end else if (!phase_ctrl) begin
              if (idx == LAST_IDX) begin
                awaddr_q   <= CTRL_ADDR;
                wdata_q    <= 32'h1;
                phase_ctrl <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
        end
        ST_POLL_R: begin
          if (m_axil_rvalid) begin
            if (m_axil_rresp != RESP_OKAY) begin
              error_q <= 1'b1;
            end else if (!m_axil_rdata[0]) begin
              if (poll_cnt == POLL_LAST) error_q <= 1'b1;
              else                       poll_cnt <= poll_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state so every valid is glitch-free.
  always_comb begin
    s_bias_tready  = 1'b0;
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_arvalid = 1'b0;
    m_axil_araddr  = '0;
    m_axil_rready  = 1'b0;
    busy           = (state != ST_IDLE);
    done           = 1'b0;
    unique case (state)
      ST_FETCH:   s_bias_tready = 1'b1;
      ST_WRITE: begin
        m_axil_awvalid = !aw_done;
        m_axil_wvalid  = !w_done;
      end
      ST_WRESP:   m_axil_bready = 1'b1;
      ST_POLL_AR: begin
        m_axil_arvalid = 1'b1;
        m_axil_araddr  = STATUS_ADDR;
      end
      ST_POLL_R:  m_axil_rready = 1'b1;
      ST_FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  assign error         = error_q;
  assign m_axil_awaddr = awaddr_q;
  assign m_axil_wdata  = wdata_q;
  assign m_axil_awprot = 3'b000;
  assign m_axil_arprot = 3'b000;
  assign m_axil_wstrb  = 4'hF;

endmodule

// File: tb/tb_bias_config_sequencer.sv
// Bench for bias_config_sequencer: behavioural AXI4-Lite register slave and
// bias-word source with configurable latencies, scenario table, scoreboard.
module tb_bias_config_sequencer;
  import mnist_axil_pkg::*;

  localparam int NB = 18;
  localparam int PL = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [31:0] s_bias_tdata = '0;
  logic        s_bias_tvalid = 1'b0;
  logic        s_bias_tready;
  logic [4:0]  m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready;
  logic        m_axil_awready = 1'b0, m_axil_wready = 1'b0, m_axil_bvalid = 1'b0;
  logic        m_axil_arready = 1'b0, m_axil_rvalid = 1'b0;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_bresp = 2'b00, m_axil_rresp = 2'b00;
  logic [31:0] m_axil_rdata = '0;

  always #5 aclk = ~aclk;

  bias_config_sequencer #(.ADDR_W(5), .NUM_BIAS(NB), .POLL_LIMIT(PL)) u_dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .busy(busy), .done(done), .error(error),
    .s_bias_tdata(s_bias_tdata), .s_bias_tvalid(s_bias_tvalid), .s_bias_tready(s_bias_tready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave/source knobs (written by the test, read by the models)
  int aw_dly = 0, w_dly = 0, stall_at = -1, zeros = 0, err_at = -1;

  // Slave/source model state
  logic [31:0] regs [0:31];
  int aw_cnt = 0, w_cnt = 0, n_aw = 0, n_w = 0, n_b = 0, n_ar = 0;
  int src_i = 0, stall_cnt = 0;
  bit aw_got = 0, w_got = 0;
  bit aw_f = 0, w_f = 0, b_f = 0, ar_f = 0, r_f = 0, t_f = 0;
  logic [4:0]  aw_cap = '0, got_addr = '0;
  logic [31:0] w_cap = '0, got_data = '0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_wr_t;
  exp_wr_t sb[$];

  // Models act on the falling edge: commit handshakes taken at the previous
  // rising edge, then set up ready/valid for the next one.
  always @(negedge aclk) begin
    exp_wr_t e;
    if (!aresetn) begin
      m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0;
      m_axil_arready = 0; m_axil_rvalid = 0; s_bias_tvalid = 0;
      aw_cnt = 0; w_cnt = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0;
      src_i = 0; stall_cnt = 0; aw_got = 0; w_got = 0;
      aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0; t_f = 0;
    end else begin
      if (t_f) begin
        sb.push_back('{a: src_i[4:0], d: 32'h100 + src_i});
        if (src_i == NB - 1) sb.push_back('{a: 5'd18, d: 32'h1});
        src_i++;
      end
      if (aw_f) begin aw_got = 1; got_addr = aw_cap; n_aw++; end
      if (w_f)  begin w_got = 1;  got_data = w_cap;  n_w++;  end
      if (b_f)  m_axil_bvalid = 0;
      if (r_f)  m_axil_rvalid = 0;
      if (ar_f) begin
        m_axil_rvalid = 1;
        m_axil_rresp  = 2'b00;
        m_axil_rdata  = (n_ar < zeros) ? 32'h0 : 32'h1;
        n_ar++;
      end
      if (aw_got && w_got) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected_write: addr %0h data %0h with nothing expected", got_addr, got_data);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", {27'b0, got_addr}, {27'b0, e.a});
          chk("wr_data", got_data, e.d);
        end
        if (n_b == err_at) m_axil_bresp = 2'b10;
        else begin m_axil_bresp = 2'b00; regs[got_addr] = got_data; end
        m_axil_bvalid = 1; n_b++;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
      end
      m_axil_awready = m_axil_awvalid && !aw_got && (aw_cnt >= aw_dly);
      if (m_axil_awvalid && !aw_got && !m_axil_awready) aw_cnt++;
      m_axil_wready = m_axil_wvalid && !w_got && (w_cnt >= w_dly);
      if (m_axil_wvalid && !w_got && !m_axil_wready) w_cnt++;
      m_axil_arready = m_axil_arvalid;
      if (stall_at >= 0 && src_i == stall_at && stall_cnt < 5) begin
        s_bias_tvalid = 0;
        if (stall_cnt == 4)
          chk("stall_in_fetch", {29'b0, s_bias_tready, m_axil_awvalid, m_axil_wvalid}, 32'b100);
        stall_cnt++;
      end else begin
        s_bias_tvalid = 1;
        s_bias_tdata  = 32'h100 + src_i;
      end
      aw_f = m_axil_awvalid && m_axil_awready; aw_cap = m_axil_awaddr;
      w_f  = m_axil_wvalid && m_axil_wready;   w_cap  = m_axil_wdata;
      b_f  = m_axil_bvalid && m_axil_bready;
      ar_f = m_axil_arvalid && m_axil_arready;
      r_f  = m_axil_rvalid && m_axil_rready;
      t_f  = s_bias_tvalid && s_bias_tready;
    end
  end

  task automatic do_reset();
    @(posedge aclk); #1 aresetn = 0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    sb.delete();
    for (int i = 0; i < 32; i++) regs[i] = '0;
  endtask

  // Pulse start, check FETCH is entered next cycle, wait (bounded) for end.
  task automatic run_seq(input string nm, output bit dn, output bit er, output bit both);
    dn = 0; er = 0; both = 0;
    @(posedge aclk); #1 start = 1;
    @(posedge aclk); #1 start = 0;
    chk({nm, "_start"}, {29'b0, busy, s_bias_tready, error}, 32'b110);
    for (int c = 0; c < 3000 && !dn && !er; c++) begin
      @(posedge aclk); #1;
      if (done && error) both = 1;
      if (done)  dn = 1;
      if (error) er = 1;
    end
    if (!dn && !er) begin
      checks++; errors++;
      $display("FAIL %s_timeout: neither done nor error within 3000 cycles", nm);
    end
    if (dn) begin
      @(posedge aclk); #1;
      chk({nm, "_done_pulse"}, {30'b0, done, busy}, 32'b0);
    end
  endtask

  function automatic int regs_bad();
    int bad = 0;
    for (int i = 0; i < NB; i++) if (regs[i] !== 32'h100 + i) bad++;
    if (regs[18] !== 32'h1) bad++;
    return bad;
  endfunction

  typedef struct {
    string nm;
    int aw_dly, w_dly, stall_at, zeros, err_at;
    int exp_wr, exp_rd;
    bit exp_done, exp_err;
  } vec_t;
  vec_t vecs[8];

  initial begin
    bit dn, er, both;
    vecs[0] = '{"zero_wait",   0, 0, -1,    0, -1, 19, 1, 1, 0};
    vecs[1] = '{"w_before_aw", 3, 0, -1,    0, -1, 19, 1, 1, 0};
    vecs[2] = '{"aw_before_w", 0, 2, -1,    0, -1, 19, 1, 1, 0};
    vecs[3] = '{"both_slow",   2, 2, -1,    0, -1, 19, 1, 1, 0};
    vecs[4] = '{"src_stall",   0, 0,  7,    0, -1, 19, 1, 1, 0};
    vecs[5] = '{"poll_4_zero", 0, 0, -1,    4, -1, 19, 5, 1, 0};
    vecs[6] = '{"poll_stuck",  0, 0, -1, 1000, -1, 19, PL, 0, 1};
    vecs[7] = '{"bresp_err",   0, 0, -1,    0,  5,  6, 0, 0, 1};

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_ctrl", {23'b0, m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                     m_axil_rready, s_bias_tready, busy, done, error}, 32'b0);
    chk("rst_addr", {22'b0, m_axil_awaddr, m_axil_araddr}, 32'b0);
    chk("rst_const", {22'b0, m_axil_awprot, m_axil_arprot, m_axil_wstrb}, 32'h00F);
    #1 aresetn = 1;

    foreach (vecs[k]) begin
      aw_dly = vecs[k].aw_dly; w_dly = vecs[k].w_dly; stall_at = vecs[k].stall_at;
      zeros = vecs[k].zeros; err_at = vecs[k].err_at;
      do_reset();
      run_seq(vecs[k].nm, dn, er, both);
      repeat (3) @(posedge aclk);
      #1;
      chk({vecs[k].nm, "_done"},  {31'b0, dn}, {31'b0, vecs[k].exp_done});
      chk({vecs[k].nm, "_error"}, {31'b0, er}, {31'b0, vecs[k].exp_err});
      chk({vecs[k].nm, "_both"},  {31'b0, both}, 32'b0);
      chk({vecs[k].nm, "_writes"}, n_b, vecs[k].exp_wr);
      chk({vecs[k].nm, "_aw_hs"},  n_aw, vecs[k].exp_wr);
      chk({vecs[k].nm, "_reads"},  n_ar, vecs[k].exp_rd);
      chk({vecs[k].nm, "_sb_left"}, sb.size(), 0);
      chk({vecs[k].nm, "_idle"}, {31'b0, busy}, 32'b0);
      if (vecs[k].exp_wr == 19) chk({vecs[k].nm, "_regs"}, regs_bad(), 0);
    end

    // After the bresp error: stays idle, error sticky, then restart from 0.
    repeat (10) @(posedge aclk);
    #1;
    chk("err_no_more_aw", n_aw, 6);
    chk("err_sticky", {31'b0, error}, 32'b1);
    err_at = -1;
    src_i = 0; stall_cnt = 0;
    sb.delete();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    run_seq("restart", dn, er, both);
    repeat (3) @(posedge aclk);
    #1;
    chk("restart_done", {30'b0, dn, er}, 32'b10);
    chk("restart_writes", n_b, 6 + 19);
    chk("restart_regs", regs_bad(), 0);
    chk("restart_sb_left", sb.size(), 0);

    // Reset in the middle of write 10 while AW is still waiting.
    aw_dly = 5; w_dly = 0; stall_at = -1; zeros = 0;
    do_reset();
    @(posedge aclk); #1 start = 1;
    @(posedge aclk); #1 start = 0;
    begin
      bit hit = 0;
      for (int c = 0; c < 2000 && !hit; c++) begin
        @(posedge aclk); #1;
        if (n_b == 10 && m_axil_awvalid) hit = 1;
      end
      if (!hit) begin
        checks++; errors++;
        $display("FAIL midrst_reach_write10: write 10 never observed");
      end
    end
    aresetn = 0;
    @(posedge aclk); #1;
    chk("midrst_outputs", {29'b0, m_axil_awvalid, m_axil_wvalid, busy}, 32'b0);
    aresetn = 1;
    aw_dly = 0;
    sb.delete();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    @(posedge aclk); #1;
    run_seq("after_rst", dn, er, both);
    repeat (3) @(posedge aclk);
    #1;
    chk("after_rst_done", {30'b0, dn, er}, 32'b10);
    chk("after_rst_writes", n_b, 19);
    chk("after_rst_regs", regs_bad(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
